// File: rtl/interleaver_addr_ctr_if.sv
// Control/address bundle between the interleaver FSM and one RAM address
// counter.
interface interleaver_addr_ctr_if #(
  parameter int ADDR_W = 13
);
  logic              ctr_re;
  logic              ctr_en;
  logic              ctr_blk;
  logic              pmode;
  logic [ADDR_W-1:0] addr;
  logic              finish;
  logic              busy;

  modport master (
    output ctr_re, ctr_en, ctr_blk, pmode,
    input  addr, finish, busy
  );

  modport slave (
    input  ctr_re, ctr_en, ctr_blk, pmode,
    output addr, finish, busy
  );
endinterface

// File: rtl/interleaver_addr_ctr.sv
// Interleaver RAM address sequencer: linear 0..K-1 or LTE QPP permuted
// addresses, computed incrementally with modular adds only.
module interleaver_addr_ctr #(
  parameter int ADDR_W   = 13,
  parameter int K_SMALL  = 1056,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int K_LARGE  = 6144,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  interleaver_addr_ctr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  typedef logic [ADDR_W:0]   wide_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam wide_t KS  = wide_t'(K_SMALL);
  localparam wide_t KL  = wide_t'(K_LARGE);
  localparam addr_t G0S = addr_t'(F1_SMALL + F2_SMALL);
  localparam addr_t G0L = addr_t'(F1_LARGE + F2_LARGE);
  localparam addr_t D2S = addr_t'(2 * F2_SMALL);
  localparam addr_t D2L = addr_t'(2 * F2_LARGE);

  state_t r_state;
  addr_t  r_idx;
  addr_t  r_pi;
  addr_t  r_g;
  logic   r_blk;
  logic   r_pmode;

  wide_t w_k;
  addr_t w_kmax;
  addr_t w_d2;
  addr_t w_g0;
  addr_t w_g0_new;
  addr_t w_pi_nxt;
  addr_t w_g_nxt;
  logic  w_last;

  // Both operands are already reduced, so one conditional subtract suffices.
  function automatic addr_t mod_add(addr_t a, addr_t b, wide_t k);
    wide_t s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= k) s = s - k;
    return s[ADDR_W-1:0];
  endfunction

  assign w_k      = r_blk ? KL : KS;
  assign w_kmax   = addr_t'(w_k - wide_t'(1));
  assign w_d2     = r_blk ? D2L : D2S;
  assign w_g0     = r_blk ? G0L : G0S;
  assign w_g0_new = bus.ctr_blk ? G0L : G0S;
  assign w_last   = (r_idx == w_kmax);
  assign w_pi_nxt = mod_add(r_pi, r_g, w_k);
  assign w_g_nxt  = mod_add(r_g, w_d2, w_k);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pi    <= '0;
      r_g     <= '0;
      r_blk   <= 1'b0;
      r_pmode <= 1'b0;
    end else if (bus.ctr_re) begin
      r_state <= S_ACTIVE;
      r_idx   <= '0;
      r_pi    <= '0;
      r_g     <= w_g0_new;
      r_blk   <= bus.ctr_blk;
      r_pmode <= bus.pmode;
    end else if (r_state == S_ACTIVE && bus.ctr_en) begin
      if (w_last) begin
        r_state <= S_DONE;
        r_idx   <= '0;
        r_pi    <= '0;
        r_g     <= w_g0;
      end else begin
        r_idx <= r_idx + addr_t'(1);
        r_pi  <= w_pi_nxt;
        r_g   <= w_g_nxt;
      end
    end
  end

  assign bus.addr   = r_pmode ? r_pi : r_idx;
  assign bus.finish = (r_state == S_ACTIVE) && w_last;
  assign bus.busy   = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_interleaver_addr_ctr.sv
// Bench for interleaver_addr_ctr: random enables/config against a closed-form
// QPP reference model.
module tb_interleaver_addr_ctr;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  interleaver_addr_ctr_if #(.ADDR_W(AW)) dut_if ();

  interleaver_addr_ctr #(.ADDR_W(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // model: 0=idle 1=active 2=done
  int m_state, m_i, m_blk, m_pm;
  bit seen[8192];

  function automatic int kof(int b);
    return b != 0 ? 6144 : 1056;
  endfunction

  function automatic int qpp(int b, int i);
    longint k, f1, f2, li;
    k  = (b != 0) ? 6144 : 1056;
    f1 = (b != 0) ? 263 : 17;
    f2 = (b != 0) ? 480 : 66;
    li = longint'(i);
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  function automatic int exp_addr();
    return (m_pm != 0) ? qpp(m_blk, m_i) : m_i;
  endfunction

  function automatic bit exp_fin();
    return (m_state == 1) && (m_i == kof(m_blk) - 1);
  endfunction

  function automatic bit exp_busy();
    return m_state == 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_i = 0; m_blk = 0; m_pm = 0;
  endtask

  task automatic drive(bit re, bit en, bit blk, bit pm);
    dut_if.ctr_re  = re;
    dut_if.ctr_en  = en;
    dut_if.ctr_blk = blk;
    dut_if.pmode   = pm;
    if (!reset) begin
      if (re) begin
        m_i = 0; m_blk = blk; m_pm = pm; m_state = 1;
      end else if (m_state == 1 && en) begin
        if (m_i == kof(m_blk) - 1) begin
          m_i = 0; m_state = 2;
        end else begin
          m_i++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dut_if.ctr_re = 0; dut_if.ctr_en = 0;
    dut_if.ctr_blk = 0; dut_if.pmode = 0;
    model_reset();
    #3;
    checks++;
    if (dut_if.addr !== '0 || dut_if.finish !== 1'b0 || dut_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init addr=%0d fin=%0b busy=%0b want 0/0/0",
               dut_if.addr, dut_if.finish, dut_if.busy);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 1'($urandom), 1'($urandom));
      checks++;
      if (dut_if.addr !== '0 || dut_if.busy !== 1'b0 || dut_if.finish !== 1'b0) begin
        errors++;
        $display("FAIL idle_en addr=%0d busy=%0b fin=%0b want 0/0/0",
                 dut_if.addr, dut_if.busy, dut_if.finish);
      end
    end
    drive(1, 0, 0, 1);
    for (int c = 0; c < 300; c++) drive(0, 1, 0, 0);
    checks++;
    if (dut_if.addr !== AW'(exp_addr()) || dut_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset addr=%0d busy=%0b want %0d/1",
               dut_if.addr, dut_if.busy, exp_addr());
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_if.addr !== '0 || dut_if.finish !== 1'b0 || dut_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid addr=%0d fin=%0b busy=%0b want 0/0/0",
               dut_if.addr, dut_if.finish, dut_if.busy);
    end
    drive(0, 1, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1'($urandom), 1'($urandom));
      checks++;
      if (dut_if.addr !== '0 || dut_if.busy !== 1'b0 || dut_if.finish !== 1'b0) begin
        errors++;
        $display("FAIL post_reset addr=%0d busy=%0b fin=%0b want 0/0/0",
                 dut_if.addr, dut_if.busy, dut_if.finish);
      end
    end
  endtask

  task automatic test_linear();
    int guard;
    bit en;
    drive(1, 0, 0, 0);
    guard = 0;
    while (m_state == 1 && guard < 3000) begin
      en = ($urandom_range(0, 5) != 0);
      drive(0, en, 1'($urandom), 1'($urandom));
      guard++;
      checks++;
      if (dut_if.addr !== AW'(exp_addr()) || dut_if.finish !== exp_fin() ||
          dut_if.busy !== exp_busy()) begin
        errors++;
        $display("FAIL linear i=%0d addr=%0d/%0d fin=%0b/%0b busy=%0b/%0b",
                 m_i, dut_if.addr, exp_addr(), dut_if.finish, exp_fin(),
                 dut_if.busy, exp_busy());
      end
    end
    if (m_state == 1) begin
      errors++;
      $display("FAIL linear_timeout i=%0d want done", m_i);
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 1, 0, 0);
      checks++;
      if (dut_if.addr !== '0 || dut_if.busy !== 1'b0 || dut_if.finish !== 1'b0) begin
        errors++;
        $display("FAIL done_hold addr=%0d busy=%0b fin=%0b want 0/0/0",
                 dut_if.addr, dut_if.busy, dut_if.finish);
      end
    end
  endtask

  task automatic test_qpp(bit blk);
    int guard, prev, ndist, k, last;
    bit en;
    k    = kof(blk);
    last = blk ? 217 : 49;
    foreach (seen[j]) seen[j] = 1'b0;
    drive(1, 0, blk, 1);
    seen[0] = 1'b1;
    ndist = 1;
    guard = 0;
    while (m_state == 1 && guard < 10000) begin
      prev = m_i;
      en = ($urandom_range(0, 7) != 0);
      drive(0, en, 1'($urandom), 1'($urandom));
      guard++;
      checks++;
      if (dut_if.addr !== AW'(exp_addr()) || dut_if.finish !== exp_fin() ||
          dut_if.busy !== exp_busy()) begin
        errors++;
        $display("FAIL qpp%0d i=%0d addr=%0d/%0d fin=%0b/%0b busy=%0b/%0b",
                 blk, m_i, dut_if.addr, exp_addr(), dut_if.finish, exp_fin(),
                 dut_if.busy, exp_busy());
      end
      if (m_state == 1 && m_i != prev) begin
        if (seen[dut_if.addr]) begin
          errors++;
          $display("FAIL qpp%0d_dup i=%0d addr=%0d repeated", blk, m_i, dut_if.addr);
        end else begin
          seen[dut_if.addr] = 1'b1;
          ndist++;
        end
      end
      if (m_state == 1 && m_i == k - 1) begin
        checks++;
        if (dut_if.addr !== AW'(last) || dut_if.finish !== 1'b1) begin
          errors++;
          $display("FAIL qpp%0d_last addr=%0d fin=%0b want %0d/1",
                   blk, dut_if.addr, dut_if.finish, last);
        end
      end
    end
    checks++;
    if (ndist != k) begin
      errors++;
      $display("FAIL qpp%0d_cover distinct=%0d want %0d", blk, ndist, k);
    end
  endtask

  task automatic test_stall_priority();
    drive(1, 0, 0, 1);
    for (int c = 0; c < 500; c++) drive(0, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1'($urandom), 1'($urandom));
      checks++;
      if (dut_if.addr !== AW'(qpp(0, 500)) || dut_if.finish !== 1'b0 ||
          dut_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall addr=%0d fin=%0b busy=%0b want %0d/0/1",
                 dut_if.addr, dut_if.finish, dut_if.busy, qpp(0, 500));
      end
    end
    drive(1, 1, 1, 0);
    checks++;
    if (dut_if.addr !== '0 || dut_if.busy !== 1'b1 || dut_if.finish !== 1'b0) begin
      errors++;
      $display("FAIL re_prio addr=%0d busy=%0b fin=%0b want 0/1/0",
               dut_if.addr, dut_if.busy, dut_if.finish);
    end
    for (int c = 0; c < 10; c++) begin
      drive(0, 1, 0, 1);
      checks++;
      if (dut_if.addr !== AW'(exp_addr()) || dut_if.busy !== exp_busy()) begin
        errors++;
        $display("FAIL re_newcfg i=%0d addr=%0d/%0d busy=%0b/%0b",
                 m_i, dut_if.addr, exp_addr(), dut_if.busy, exp_busy());
      end
    end
  endtask

  task automatic test_config_sampling();
    int n;
    drive(1, 0, 0, 1);
    n = 0;
    while (m_state == 1 && n < 2000) begin
      drive(0, 1, 1'($urandom), 1'($urandom));
      n++;
      checks++;
      if (dut_if.addr !== AW'(exp_addr()) || dut_if.finish !== exp_fin() ||
          dut_if.busy !== exp_busy()) begin
        errors++;
        $display("FAIL cfg i=%0d addr=%0d/%0d fin=%0b/%0b busy=%0b/%0b",
                 m_i, dut_if.addr, exp_addr(), dut_if.finish, exp_fin(),
                 dut_if.busy, exp_busy());
      end
    end
    checks++;
    if (n != 1056) begin
      errors++;
      $display("FAIL cfg_len enables=%0d want 1056", n);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0);
    for (int c = 0; c < 1055; c++) drive(0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 1);
      checks++;
      if (dut_if.addr !== AW'(1055) || dut_if.finish !== 1'b1 || dut_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL fin_hold addr=%0d fin=%0b busy=%0b want 1055/1/1",
                 dut_if.addr, dut_if.finish, dut_if.busy);
      end
    end
    drive(1, 1, 0, 1);
    checks++;
    if (dut_if.addr !== '0 || dut_if.busy !== 1'b1 || dut_if.finish !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart addr=%0d busy=%0b fin=%0b want 0/1/0",
               dut_if.addr, dut_if.busy, dut_if.finish);
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 1, 0);
      checks++;
      if (dut_if.addr !== AW'(exp_addr()) || dut_if.busy !== exp_busy()) begin
        errors++;
        $display("FAIL b2b_seq i=%0d addr=%0d/%0d busy=%0b/%0b",
                 m_i, dut_if.addr, exp_addr(), dut_if.busy, exp_busy());
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_qpp(1'b0);
    test_qpp(1'b1);
    test_stall_priority();
    test_config_sampling();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
